sccb_ov5640_wr_ctrl: RTL and testbench
======================================

# sccb_ov5640_wr_ctrl

SCCB (I2C-compatible) 3-phase write master for the OV5640 camera, sitting directly downstream of the register-table sequencer. It accepts one 24-bit {register address[15:0], data[7:0]} word per `sccb_exec` pulse and serialises it onto SCL/SDA as ID / address-high / address-low / data bytes. It returns a one-cycle `sccb_done` pulse, which the sequencer uses to advance to the next table entry.

## Interface
- `SLAVE_ADDR`, 7'h3c: 7-bit device address; the write ID byte is {SLAVE_ADDR, 1'b0} = 8'h78.
- `CLK_FREQ`, 26'd1_000_000: `clk` frequency in Hz.
- `SCL_FREQ`, 18'd250_000: SCL frequency in Hz.
- Derived `QDIV` = CLK_FREQ / (4*SCL_FREQ), truncated; must be ≥1. This is the number of clk cycles per quarter SCL period.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `sccb_exec`  in  1  one-cycle start request.
- `sccb_data`  in  24  [23:8] register address, [7:0] register data.
- `sccb_done`  out  1  one-cycle pulse at the end of a transaction.
- `sccb_busy`  out  1  high while a transaction is in progress.
- `ack_err`  out  1  at least one ACK slot was sampled high in the last transaction.
- `scl`  out  1  SCCB clock (push-pull).
- `sda_out`  out  1  SDA drive value.
- `sda_oe`  out  1  SDA output enable; the top level builds the open-drain pin as `sda_oe ? sda_out : 1'bz`.
- `sda_in`  in  1  sampled SDA pin.

## Operation
- Reset values: `scl`=1, `sda_out`=1, `sda_oe`=0, `sccb_done`=0, `sccb_busy`=0, `ack_err`=0, state IDLE, counters 0.
- A quarter tick fires every QDIV cycles. All bus activity is divided into 4-quarter slots (q0..q3).
- States: IDLE → START → BYTE → ACK → (BYTE if bytes remain, else STOP) → IDLE.
- **IDLE**:
  - `sccb_exec`=1 latches `sccb_data` into a shift register, clears `ack_err`, and moves to START.
  - `sccb_data` changes after the accept cycle have no effect.
- **START**:
  - q0 and q1: `sda_oe`=1, `sda_out`=1, `scl`=1.
  - q2: `sda_out`=0, with `scl` still 1.
  - q3: `scl`=0.
- **BYTE**: 8 bit slots, MSB first.
  - Byte order: 8'h78, addr[15:8], addr[7:0], data.
  - Per bit: q0 `scl`=0 and SDA driven; q1 and q2 `scl`=1; q3 `scl`=0.
- **ACK**: one slot with `sda_oe`=0.
  - `sda_in` is sampled at the start of q2.
  - A sample of 1 sets `ack_err`.
  - The transaction continues regardless, since SCCB treats the 9th bit as don't-care.
- **STOP**:
  - q0: `sda_oe`=1, `sda_out`=0, `scl`=0.
  - q1: `scl`=1.
  - q2 and q3: `sda_out`=1.
- **Return to IDLE** after STOP q3:
  - `sda_oe`=0, `scl`=1.
  - `sccb_done` pulses for 1 cycle.
  - `ack_err` is held until the next accept.
- A transaction is exactly 4 + 4·9·4 + 4 = 152 quarters.
- `sccb_exec` while `sccb_busy`=1 is ignored. It is not queued.
- `sccb_exec` in the same cycle as `sccb_done` is accepted.
- `rst` mid-transaction:
  - Takes effect on the next edge and restores all reset values.
  - The bus is released (SCL high, SDA released) without a STOP.
  - No `sccb_done` is generated.

## Timing
- `sccb_exec` accepted at cycle T:
  - Quarter 1 occupies cycles T+1 .. T+QDIV.
  - `sccb_busy`=1 from T+1 through T+152·QDIV.
  - At T+152·QDIV+1: `sccb_done`=1 and `sccb_busy`=0.
- With defaults (QDIV=1):
  - SCL period is 4 cycles.
  - `sccb_done` arrives at T+153.
- SDA changes only while `scl`=0, except the START edge (START q2) and the STOP edge (STOP q2).
- `ack_err` is valid in the `sccb_done` cycle and stays stable until the next accept.

## Test plan
- **Single write.**
  - Stimulus: defaults, `sccb_data`=24'h3008_82, `sda_in`=0 in all ACK slots.
  - Required: bytes decoded on SCL rising edges are 0x78, 0x30, 0x08, 0x82; START and STOP present; `sccb_done` at T+153; `ack_err`=0.
- **NACK.**
  - Stimulus: `sda_in`=1 only in the 2nd ACK slot.
  - Required: all 4 bytes are still sent; `ack_err`=1 in the `sccb_done` cycle; `ack_err` clears on the next accept.
- **Busy / back-to-back.**
  - Stimulus: `sccb_exec` at T+50 while busy, then `sccb_exec` in the cycle after `sccb_done` with 24'h3103_02.
  - Required: the first extra pulse is ignored; the second transaction sends 0x78, 0x31, 0x03, 0x02, and its `sccb_done` arrives 153 cycles after its accept.
- **Reset mid-transfer.**
  - Stimulus: assert `rst` during the address-low byte.
  - Required: next cycle shows `scl`=1, `sda_oe`=0, `sccb_busy`=0; no `sccb_done`; a subsequent `sccb_exec` completes normally.
- **Divider.**
  - Stimulus: `CLK_FREQ`=50_000_000, `SCL_FREQ`=250_000 (QDIV=50).
  - Required: SCL high and low are each 100 cycles; `sccb_done` at T+7601.
- **Input latching.**
  - Stimulus: change `sccb_data` every cycle after accept.
  - Required: the transmitted bytes match the value present at the accept cycle.

Source files
------------

// File: rtl/sccb_ov5640_wr_ctrl.sv
// SCCB 3-phase write master for the OV5640.
// Takes one {reg_addr[15:0], reg_data[7:0]} word per sccb_exec pulse and
// sends it on SCL/SDA as ID, address-high, address-low and data bytes.
// Every bus phase is a slot of four quarters. One quarter lasts QDIV clk cycles.
module sccb_ov5640_wr_ctrl #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h3c,
    parameter logic [25:0] CLK_FREQ   = 26'd1_000_000,
    parameter logic [17:0] SCL_FREQ   = 18'd250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sccb_exec,
    input  logic [23:0] sccb_data,
    output logic        sccb_done,
    output logic        sccb_busy,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_out,
    output logic        sda_oe,
    input  logic        sda_in
);

    // Quarter-period length in clk cycles. It is clamped to at least one cycle.
    localparam int QDIV_RAW = int'(CLK_FREQ) / (4 * int'(SCL_FREQ));
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int QW       = (QDIV < 2) ? 1 : $clog2(QDIV);
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Bus levels for one position inside a slot, returned as {scl, sda_oe, sda_out}.
    // SCL is high in quarters 1 and 2 of data and ACK slots.
    // SDA changes in quarter 0, while SCL is low.
    function automatic logic [2:0] bus_drive(input state_t st, input logic [1:0] q,
                                             input logic bit_v);
        logic       scl_v;
        logic [2:0] r;
        scl_v = (q == 2'd1) || (q == 2'd2);
        case (st)
            ST_START: begin
                case (q)
                    2'd0, 2'd1: r = 3'b111;
                    2'd2:       r = 3'b110;
                    default:    r = 3'b010;
                endcase
            end
            ST_BYTE:  r = {scl_v, 1'b1, bit_v};
            ST_ACK:   r = {scl_v, 1'b0, 1'b1};
            ST_STOP: begin
                case (q)
                    2'd0:    r = 3'b010;
                    2'd1:    r = 3'b110;
                    default: r = 3'b111;
                endcase
            end
            default:  r = 3'b101;
        endcase
        return r;
    endfunction

    state_t        state_r;
    logic [1:0]    quarter_r;
    logic [QW-1:0] qcnt_r;
    logic [2:0]    bit_r;
    logic [1:0]    byte_r;
    logic [31:0]   shift_r;

    state_t        state_nxt_s;
    logic [1:0]    quarter_nxt_s;
    logic [2:0]    bit_nxt_s;
    logic [1:0]    byte_nxt_s;
    logic [31:0]   shift_nxt_s;
    logic          done_nxt_s;
    logic          tick_s;
    logic          accept_s;
    logic          ack_sample_s;

    assign tick_s       = (state_r != ST_IDLE) && (qcnt_r == QMAX);
    assign accept_s     = (state_r == ST_IDLE) && sccb_exec;
    assign ack_sample_s = (state_r == ST_ACK) && (quarter_r == 2'd2) &&
                          (qcnt_r == {QW{1'b0}});

    // Work out the bus position that follows the current quarter: the next slot, bit or byte.
    always_comb begin
        state_nxt_s   = state_r;
        quarter_nxt_s = quarter_r;
        bit_nxt_s     = bit_r;
        byte_nxt_s    = byte_r;
        shift_nxt_s   = shift_r;
        done_nxt_s    = 1'b0;
        if (accept_s) begin
            state_nxt_s   = ST_START;
            quarter_nxt_s = 2'd0;
            bit_nxt_s     = 3'd7;
            byte_nxt_s    = 2'd0;
            shift_nxt_s   = {SLAVE_ADDR, 1'b0, sccb_data};
        end else if (tick_s) begin
            if (quarter_r != 2'd3) begin
                quarter_nxt_s = quarter_r + 2'd1;
            end else begin
                quarter_nxt_s = 2'd0;
                case (state_r)
                    ST_START: begin
                        state_nxt_s = ST_BYTE;
                        bit_nxt_s   = 3'd7;
                    end
                    ST_BYTE: begin
                        shift_nxt_s = {shift_r[30:0], 1'b0};
                        if (bit_r == 3'd0) begin
                            state_nxt_s = ST_ACK;
                        end else begin
                            bit_nxt_s = bit_r - 3'd1;
                        end
                    end
                    ST_ACK: begin
                        if (byte_r == 2'd3) begin
                            state_nxt_s = ST_STOP;
                        end else begin
                            state_nxt_s = ST_BYTE;
                            byte_nxt_s  = byte_r + 2'd1;
                            bit_nxt_s   = 3'd7;
                        end
                    end
                    ST_STOP: begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end
                    default: state_nxt_s = ST_IDLE;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Sequencer state, quarter divider and registered bus outputs.
    // The outputs are registered from the next position, so they change together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            quarter_r <= 2'd0;
            qcnt_r    <= {QW{1'b0}};
            bit_r     <= 3'd0;
            byte_r    <= 2'd0;
            shift_r   <= 32'd0;
            scl       <= 1'b1;
            sda_out   <= 1'b1;
            sda_oe    <= 1'b0;
            sccb_done <= 1'b0;
            sccb_busy <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            quarter_r <= quarter_nxt_s;
            bit_r     <= bit_nxt_s;
            byte_r    <= byte_nxt_s;
            shift_r   <= shift_nxt_s;
            if (accept_s || tick_s || (state_r == ST_IDLE)) begin
                qcnt_r <= {QW{1'b0}};
            end else begin
                qcnt_r <= qcnt_r + QW'(1);
            end
            {scl, sda_oe, sda_out} <= bus_drive(state_nxt_s, quarter_nxt_s, shift_nxt_s[31]);
            sccb_done <= done_nxt_s;
            sccb_busy <= (state_nxt_s != ST_IDLE);
            // The ninth bit is don't-care on SCCB, so a high ACK only sets a sticky flag.
            if (accept_s) begin
                ack_err <= 1'b0;
            end else if (ack_sample_s && sda_in) begin
                ack_err <= 1'b1;
            end else begin
                ack_err <= ack_err;
            end
        end
    end

endmodule

// File: tb/tb_sccb_ov5640_wr_ctrl.sv
// Bench for sccb_ov5640_wr_ctrl. A table of write vectors is driven into the
// default-rate instance. A bus decoder collects the bytes seen on SCL rising
// edges, and a scoreboard queue compares them with the bytes expected from each
// vector. Hand-written sequences cover: reset mid-transfer, back-to-back
// transactions, and the QDIV=50 divider instance.
module tb_sccb_ov5640_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sccb_exec = 1'b0;
    logic [23:0] sccb_data = 24'd0;
    logic        sccb_done, sccb_busy, ack_err, scl, sda_out, sda_oe;
    logic        sda_in;

    logic        exec_d = 1'b0;
    logic [23:0] data_d = 24'd0;
    logic        done_d, busy_d, ack_err_d, scl_d, sda_out_d, sda_oe_d;
    logic        sda_in_d;

    int checks = 0;
    int errors = 0;

    // Slave ACK behaviour: bit k of nack_mask makes the k-th ACK slot read high.
    logic [3:0]  nack_mask = 4'd0;

    // Bus decoder state. Only the decoder block writes these.
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    int          bitn = 0;
    logic [2:0]  fbytes = 3'd0;
    logic [7:0]  sh = 8'd0;
    logic [7:0]  rx [0:255];
    int          rx_cnt = 0;
    int          start_cnt = 0;
    int          stop_cnt = 0;

    // Divider-instance SCL run-length monitor. Only its block writes these.
    logic        prev_scl_d = 1'b1;
    int          run_len = 0;
    bit          first_run = 1'b1;
    int          hi_ok = 0;
    int          lo_ok = 0;
    int          run_bad = 0;

    // Scoreboard and read pointer. Only the stimulus process uses these.
    logic [7:0]  exp_q [$];
    int          rd_idx = 0;

    sccb_ov5640_wr_ctrl u_dut (
        .clk(clk), .rst(rst), .sccb_exec(sccb_exec), .sccb_data(sccb_data),
        .sccb_done(sccb_done), .sccb_busy(sccb_busy), .ack_err(ack_err),
        .scl(scl), .sda_out(sda_out), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    sccb_ov5640_wr_ctrl #(
        .SLAVE_ADDR(7'h3c), .CLK_FREQ(26'd50_000_000), .SCL_FREQ(18'd250_000)
    ) u_dut_div (
        .clk(clk), .rst(rst), .sccb_exec(exec_d), .sccb_data(data_d),
        .sccb_done(done_d), .sccb_busy(busy_d), .ack_err(ack_err_d),
        .scl(scl_d), .sda_out(sda_out_d), .sda_oe(sda_oe_d), .sda_in(sda_in_d)
    );

    always #5 clk = ~clk;

    // Open-drain SDA pin with a pull-up. While released inside a frame, the slave drives the ACK.
    always_comb begin
        if (sda_oe) begin
            sda_in = sda_out;
        end else if (in_frame && (fbytes != 3'd0)) begin
            sda_in = nack_mask[2'(fbytes - 3'd1)];
        end else begin
            sda_in = 1'b1;
        end
    end

    assign sda_in_d = sda_oe_d ? sda_out_d : 1'b0;

    // Decode START, STOP and data bits on the pin while a transaction is active.
    always @(negedge clk) begin
        if (!sccb_busy) begin
            in_frame = 1'b0;
        end else if (scl && prev_scl && prev_sda && !sda_in) begin
            start_cnt++;
            in_frame = 1'b1;
            bitn     = 0;
            fbytes   = 3'd0;
        end else if (scl && prev_scl && !prev_sda && sda_in) begin
            stop_cnt++;
            in_frame = 1'b0;
        end else if (scl && !prev_scl && in_frame) begin
            if (bitn < 8) begin
                sh = {sh[6:0], sda_in};
                bitn++;
                if (bitn == 8) begin
                    if (rx_cnt < 256) rx[rx_cnt] = sh;
                    rx_cnt++;
                    fbytes++;
                end
            end else begin
                bitn = 0;
            end
        end
        prev_scl = scl;
        prev_sda = sda_in;
    end

    // Measure complete SCL high and low runs of the divider instance while it is busy.
    always @(negedge clk) begin
        if (busy_d) begin
            if (scl_d == prev_scl_d) begin
                run_len++;
            end else begin
                if (!first_run) begin
                    if (run_len != 100) run_bad++;
                    else if (prev_scl_d) hi_ok++;
                    else lo_ok++;
                end
                first_run = 1'b0;
                run_len   = 1;
            end
        end else begin
            run_len   = 0;
            first_run = 1'b1;
        end
        prev_scl_d = scl_d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive sccb_exec for one cycle. Return just after the edge that accepts it.
    task automatic start_txn(input logic [23:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        sccb_exec = 1'b1;
        sccb_data = d;
        nack_mask = m;
        exp_q.push_back(8'h78);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        @(posedge clk); #1;
        sccb_exec = 1'b0;
    endtask

    // Follow one transaction to sccb_done, then check timing, flags and bytes.
    task automatic wait_txn(input logic exp_err, input bit scramble, input bit poke,
                            input bit chain, input logic [23:0] chain_data);
        int n;
        bit got;
        int s0;
        int p0;
        logic [7:0] eb;
        logic [7:0] gb;
        s0  = start_cnt;
        p0  = stop_cnt;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (scramble) sccb_data = 24'($urandom);
            if (poke) sccb_exec = (n == 50);
            if (n == 1) begin
                check("busy_after_accept", 32'(sccb_busy), 32'd1);
                check("ack_err_cleared", 32'(ack_err), 32'd0);
            end
            if (n == 152) begin
                check("busy_last_quarter", 32'(sccb_busy), 32'd1);
                check("done_not_early", 32'(sccb_done), 32'd0);
            end
            if (sccb_done) begin
                got = 1'b1;
                check("done_latency", 32'(n), 32'd153);
                check("busy_at_done", 32'(sccb_busy), 32'd0);
                check("ack_err_at_done", 32'(ack_err), 32'(exp_err));
                if (chain) begin
                    sccb_exec = 1'b1;
                    sccb_data = chain_data;
                    nack_mask = 4'd0;
                    exp_q.push_back(8'h78);
                    exp_q.push_back(chain_data[23:16]);
                    exp_q.push_back(chain_data[15:8]);
                    exp_q.push_back(chain_data[7:0]);
                end
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("bytes_sent", 32'(rx_cnt - rd_idx), 32'd4);
        for (int k = 0; k < 4; k++) begin
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            if (rd_idx < rx_cnt) begin
                gb = rx[rd_idx];
                rd_idx++;
            end else begin
                gb = 8'hxx;
            end
            check("byte", 32'(gb), 32'(eb));
        end
        check("start_seen", 32'(start_cnt - s0), 32'd1);
        check("stop_seen", 32'(stop_cnt - p0), 32'd1);
    endtask

    typedef struct {
        logic [23:0] data;
        logic [3:0]  nack;
        logic        err;
        bit          scramble;
        bit          poke;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int cnt;
        bit got;

        vecs[0] = '{24'h300882, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{24'h300882, 4'b0010, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{24'h310302, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{24'ha55ac3, 4'b1000, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{24'hffffff, 4'b0001, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{24'h000000, 4'b0000, 1'b0, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({scl, sda_out, sda_oe, sccb_done, sccb_busy, ack_err}),
              32'b110000);
        check("reset_outputs_div", 32'({scl_d, sda_out_d, sda_oe_d, done_d, busy_d}),
              32'b11000);
        rst = 1'b0;

        // Table-driven single writes
        for (int i = 0; i < 6; i++) begin
            start_txn(vecs[i].data, vecs[i].nack);
            wait_txn(vecs[i].err, vecs[i].scramble, vecs[i].poke, 1'b0, 24'd0);
        end

        // Accept in the same cycle as sccb_done
        start_txn(24'h123456, 4'b0000);
        wait_txn(1'b0, 1'b0, 1'b0, 1'b1, 24'h310302);
        @(posedge clk); #1;
        sccb_exec = 1'b0;
        wait_txn(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

        // Reset during the address-low byte
        start_txn(24'h4711aa, 4'b0001);
        n = 0;
        while (!(fbytes == 3'd2 && bitn == 4) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reached_addr_low", 32'(fbytes == 3'd2 && bitn == 4), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(sccb_busy), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sccb_done) cnt++;
        end
        check("no_done_after_rst", 32'(cnt), 32'd0);
        rd_idx = rx_cnt;
        exp_q.delete();
        start_txn(24'h4711aa, 4'b0000);
        wait_txn(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);

        // Divider instance, QDIV = 50
        @(posedge clk); #1;
        exec_d = 1'b1;
        data_d = 24'h300882;
        @(posedge clk); #1;
        exec_d = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10000) begin
            @(negedge clk);
            n++;
            if (done_d) got = 1'b1;
        end
        check("div_done_seen", 32'(got), 32'd1);
        check("div_done_latency", 32'(n), 32'd7601);
        check("div_scl_high_runs", 32'(hi_ok), 32'd36);
        check("div_scl_low_runs", 32'(lo_ok), 32'd37);
        check("div_scl_bad_runs", 32'(run_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
